cond_unit: RTL and testbench

- Consumer side of the ALU flag interface: holds the architectural NZCV flag register and evaluates the 4-bit condition field of each issued instruction against it.
- Sits between decode/execute and writeback.
- Accepts one instruction per cycle over a valid/ready handshake.
- Produces a registered execute/annul decision and a branch-taken decision, and updates flags when a flag-setting instruction executes.

---
 rtl/cond_unit.sv | 118 +++++++++++
 tb/tb_cond_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluator: one instruction per cycle, registered execute/annul and branch-taken decision.
// Optional annulled-instruction counter (annul_cnt, cnt_clr) is built when COND_STATS_EN is defined.
module cond_unit #(
    parameter int FW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] cond,
    input  logic          flag_we,
    input  logic [FW-1:0] alu_flags,
    input  logic          is_branch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          cond_ex,
    output logic          take_branch,
`ifdef COND_STATS_EN
    input  logic          cnt_clr,
    output logic [15:0]   annul_cnt,
`endif
    output logic [FW-1:0] flags_q
);

    logic          out_valid_q, out_valid_d;
    logic          cond_ex_q, cond_ex_d;
    logic          take_branch_q, take_branch_d;
    logic [FW-1:0] flags_d;
    logic          accept;
    logic          base;
    logic          pass;
    logic          f_n, f_z, f_c, f_v;

    assign f_n = flags_q[3];
    assign f_z = flags_q[2];
    assign f_c = flags_q[1];
    assign f_v = flags_q[0];

    // Conditions come in true/inverted pairs: cond[0] flips the base test, except AL.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = f_z;
            3'd1:    base = f_c;
            3'd2:    base = f_n;
            3'd3:    base = f_v;
            3'd4:    base = f_c && !f_z;
            3'd5:    base = (f_n == f_v);
            3'd6:    base = !f_z && (f_n == f_v);
            default: base = 1'b1;
        endcase
    end

    assign pass     = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        cond_ex_d     = cond_ex_q;
        take_branch_d = take_branch_q;
        flags_d       = flags_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            cond_ex_d     = pass;
            take_branch_d = pass && is_branch;
            if (flag_we && pass) begin
                flags_d = alu_flags;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            cond_ex_q     <= 1'b0;
            take_branch_q <= 1'b0;
            flags_q       <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            cond_ex_q     <= cond_ex_d;
            take_branch_q <= take_branch_d;
            flags_q       <= flags_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign cond_ex     = cond_ex_q;
    assign take_branch = take_branch_q;

`ifdef COND_STATS_EN
    logic [15:0] annul_cnt_q, annul_cnt_d;

    // Clear beats a same-cycle increment; count saturates rather than wrapping.
    always_comb begin
        annul_cnt_d = annul_cnt_q;
        if (cnt_clr) begin
            annul_cnt_d = '0;
        end else if (accept && !pass && (annul_cnt_q != 16'hFFFF)) begin
            annul_cnt_d = annul_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            annul_cnt_q <= '0;
        end else begin
            annul_cnt_q <= annul_cnt_d;
        end
    end

    assign annul_cnt = annul_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios plus randomized traffic against a transaction-level reference.
module tb_cond_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cond;
    logic       flag_we;
    logic [3:0] alu_flags;
    logic       is_branch;
    logic       out_valid;
    logic       out_ready;
    logic       cond_ex;
    logic       take_branch;
    logic [3:0] flags_q;
`ifdef COND_STATS_EN
    logic        cnt_clr;
    logic [15:0] annul_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cond_unit #(.FW(4), .CW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cond        (cond),
        .flag_we     (flag_we),
        .alu_flags   (alu_flags),
        .is_branch   (is_branch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cond_ex     (cond_ex),
        .take_branch (take_branch),
`ifdef COND_STATS_EN
        .cnt_clr     (cnt_clr),
        .annul_cnt   (annul_cnt),
`endif
        .flags_q     (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table, written straight from the mnemonic definitions.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cy;
            4'b0011: return !cy;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cy && !z;
            4'b1001: return !cy || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        cond      = 4'd0;
        flag_we   = 1'b0;
        alu_flags = 4'd0;
        is_branch = 1'b0;
        out_ready = 1'b1;
`ifdef COND_STATS_EN
        cnt_clr   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] c, input logic we, input logic [3:0] af, input logic br);
        in_valid  = 1'b1;
        cond      = c;
        flag_we   = we;
        alu_flags = af;
        is_branch = br;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        flag_we   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        #1;
        checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({cond_ex, take_branch} !== 2'b00) begin errors++; $display("FAIL reset_decision got=%b exp=00", {cond_ex, take_branch}); end
        out_ready = 1'b1;
    endtask

    task automatic test_flag_eq();
        do_reset();
        issue(4'b1110, 1'b1, 4'b0100, 1'b0);
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL al_set_cond_ex got=%b exp=1", cond_ex); end
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL al_set_flags got=%b exp=0100", flags_q); end
        issue(4'b0000, 1'b0, 4'b0000, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL eq_out_valid got=%b exp=1", out_valid); end
        checks++; if ({cond_ex, take_branch} !== 2'b11) begin errors++; $display("FAIL eq_branch got=%b exp=11", {cond_ex, take_branch}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eq_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_annul();
        do_reset();
        issue(4'b0000, 1'b1, 4'b1111, 1'b1);
        checks++; if ({cond_ex, take_branch} !== 2'b00) begin errors++; $display("FAIL annul_decision got=%b exp=00", {cond_ex, take_branch}); end
        checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL annul_flags got=%b exp=0000", flags_q); end
    endtask

    task automatic test_signed();
        logic [3:0] cs [4];
        logic       e1 [4];
        logic       e2 [4];
        cs[0] = 4'b1010; cs[1] = 4'b1011; cs[2] = 4'b1100; cs[3] = 4'b1101;
        e1[0] = 1'b0; e1[1] = 1'b1; e1[2] = 1'b0; e1[3] = 1'b1;
        e2[0] = 1'b1; e2[1] = 1'b0; e2[2] = 1'b1; e2[3] = 1'b0;
        do_reset();
        issue(4'b1110, 1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(cs[i], 1'b0, 4'b0000, 1'b1);
            checks++; if ({cond_ex, take_branch} !== {e1[i], e1[i]}) begin errors++; $display("FAIL signed_n1v0 cond=%b got=%b exp=%b", cs[i], {cond_ex, take_branch}, {e1[i], e1[i]}); end
        end
        issue(4'b1110, 1'b1, 4'b1001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(cs[i], 1'b0, 4'b0000, 1'b1);
            checks++; if ({cond_ex, take_branch} !== {e2[i], e2[i]}) begin errors++; $display("FAIL signed_n1v1 cond=%b got=%b exp=%b", cs[i], {cond_ex, take_branch}, {e2[i], e2[i]}); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        issue(4'b1110, 1'b1, 4'b0010, 1'b0);
        in_valid = 1'b1; cond = 4'b0011; flag_we = 1'b1; alu_flags = 4'b1111; is_branch = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            tick();
            checks++; if ({out_valid, cond_ex, take_branch} !== 3'b110) begin errors++; $display("FAIL stall_hold cyc=%0d got=%b exp=110", i, {out_valid, cond_ex, take_branch}); end
            checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL stall_flags cyc=%0d got=%b exp=0010", i, flags_q); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if ({out_valid, cond_ex, take_branch} !== 3'b100) begin errors++; $display("FAIL release_cc got=%b exp=100", {out_valid, cond_ex, take_branch}); end
        checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL release_cc_flags got=%b exp=0010", flags_q); end
        cond = 4'b0010; alu_flags = 4'b1000;
        tick();
        checks++; if ({out_valid, cond_ex, take_branch} !== 3'b111) begin errors++; $display("FAIL b2b_cs got=%b exp=111", {out_valid, cond_ex, take_branch}); end
        checks++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL b2b_cs_flags got=%b exp=1000", flags_q); end
        in_valid = 1'b0; flag_we = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_stall();
        do_reset();
        issue(4'b1110, 1'b1, 4'b0110, 1'b1);
        out_ready = 1'b0;
        tick();
        checks++; if ({out_valid, flags_q} !== 5'b10110) begin errors++; $display("FAIL pre_rst_state got=%b exp=10110", {out_valid, flags_q}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got=%b exp=0", out_valid); end
        checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL rst_stall_flags got=%b exp=0000", flags_q); end
        checks++; if ({cond_ex, take_branch} !== 2'b00) begin errors++; $display("FAIL rst_stall_decision got=%b exp=00", {cond_ex, take_branch}); end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] m_flags;
        logic [1:0] sb[$];
        logic [1:0] exp_d;
        bit         p;
        do_reset();
        m_flags = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, flags_q, m_flags); end
            checks++; if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, sb.size() != 0); end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            cond      = 4'($urandom);
            flag_we   = 1'($urandom);
            alu_flags = 4'($urandom);
            is_branch = 1'($urandom);
            #1;
            checks++; if (in_ready !== (sb.size() == 0 || out_ready)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b", i, in_ready); end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_d = sb.pop_front();
                checks++; if ({cond_ex, take_branch} !== exp_d) begin errors++; $display("FAIL rnd_decision cyc=%0d got=%b exp=%b", i, {cond_ex, take_branch}, exp_d); end
            end
            if (in_valid && in_ready) begin
                p = ref_pass(cond, m_flags);
                sb.push_back({p, p && is_branch});
                if (p && flag_we) m_flags = alu_flags;
            end
            tick();
        end
        in_valid = 1'b0; flag_we = 1'b0; out_ready = 1'b1;
        tick();
    endtask

`ifdef COND_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (annul_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%h exp=0000", annul_cnt); end
        for (int i = 0; i < 3; i++) issue(4'b0000, 1'b0, 4'b0000, 1'b0);
        issue(4'b1110, 1'b0, 4'b0000, 1'b0);
        checks++; if (annul_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three got=%h exp=0003", annul_cnt); end
        in_valid = 1'b1; cond = 4'b0000; out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if (annul_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_wins got=%h exp=0000", annul_cnt); end
        repeat (65537) tick();
        in_valid = 1'b0;
        checks++; if (annul_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=ffff", annul_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (annul_cnt !== 16'd0) begin errors++; $display("FAIL cnt_rst got=%h exp=0000", annul_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_flag_eq();
        test_annul();
        test_signed();
        test_backpressure();
        test_reset_stall();
        test_random();
`ifdef COND_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
